// File: rtl/bt_stack_ctrl.sv
// bt_stack_ctrl: backtracking call-stack controller for the inexact-match
// search engine. Holds recursion frames {position, i, z, k, l}, issues the
// top frame to the ex path and applies each ex decision as pop/push/update.
// Optional feature: define BT_HIT_CNT_EN to build the saturating hit counter;
// without it hit_count is tied to zero.
module bt_stack_ctrl #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [7:0]                 i0,
  input  logic [7:0]                 z0,
  input  logic [7:0]                 k0,
  input  logic [7:0]                 l0,
  output logic                       ex_req,
  output logic [4:0]                 ex_position,
  output logic [7:0]                 ex_i,
  output logic [7:0]                 ex_z,
  output logic [7:0]                 ex_k,
  output logic [7:0]                 ex_l,
  input  logic                       res_valid,
  input  logic                       over_1,
  input  logic                       over_2,
  input  logic                       finish,
  input  logic                       en_new_position,
  input  logic                       new_call,
  input  logic [4:0]                 new_position,
  input  logic [7:0]                 i_new,
  input  logic [7:0]                 z_new,
  input  logic [7:0]                 k_new,
  input  logic [7:0]                 l_new,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic                       hit_valid,
  output logic [7:0]                 hit_k,
  output logic [7:0]                 hit_l,
  output logic [15:0]                hit_count,
  output logic [$clog2(DEPTH+1)-1:0] depth
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Position code of a freshly created frame (shared with the engine's config).
  localparam logic [4:0] NONE = 5'd0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [SPW-1:0]  sp_q, sp_d;
  logic [36:0]     frames_q [DEPTH];
  logic [36:0]     ex_frame_q, ex_frame_d;
  logic            ex_req_q, ex_req_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            hit_valid_q, hit_valid_d;
  logic [7:0]      hit_k_q, hit_k_d;
  logic [7:0]      hit_l_q, hit_l_d;

  // Decision latched at the res_valid edge, consumed in UPDATE.
  logic            dec_pop_q, dec_pop_d;
  logic            dec_push_q, dec_push_d;
  logic            dec_upd_q, dec_upd_d;
  logic [4:0]      dec_pos_q, dec_pos_d;
  logic [31:0]     dec_frame_q, dec_frame_d;

  logic            wr_root;
  logic            wr_push;
  logic            wr_pos;
  logic            launch;
  logic [36:0]     top_frame;
  logic [36:0]     below_frame;

  // Top frame is entry sp-1; the frame that becomes top after a pop is sp-2.
  assign top_frame   = frames_q[AW'(sp_q - SPW'(1))];
  assign below_frame = frames_q[AW'(sp_q - SPW'(2))];

  assign launch = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                            (state_q == S_ERROR));

  // Next-state and registered-output computation for the whole controller.
  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    ex_frame_d  = ex_frame_q;
    ex_req_d    = 1'b0;
    done_d      = 1'b0;
    hit_valid_d = 1'b0;
    busy_d      = busy_q;
    err_d       = err_q;
    hit_k_d     = hit_k_q;
    hit_l_d     = hit_l_q;
    dec_pop_d   = dec_pop_q;
    dec_push_d  = dec_push_q;
    dec_upd_d   = dec_upd_q;
    dec_pos_d   = dec_pos_q;
    dec_frame_d = dec_frame_q;
    wr_root     = 1'b0;
    wr_push     = 1'b0;
    wr_pos      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (launch) begin
          wr_root    = 1'b1;
          sp_d       = SPW'(1);
          err_d      = 1'b0;
          busy_d     = 1'b1;
          ex_req_d   = 1'b1;
          ex_frame_d = {NONE, i0, z0, k0, l0};
          state_d    = S_ISSUE;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (res_valid) begin
          dec_pop_d   = over_1 | over_2 | finish;
          dec_push_d  = new_call;
          dec_upd_d   = en_new_position;
          dec_pos_d   = new_position;
          dec_frame_d = {i_new, z_new, k_new, l_new};
          // over_2 reports the frame being popped as a hit.
          if (over_2) begin
            hit_valid_d = 1'b1;
            hit_k_d     = top_frame[15:8];
            hit_l_d     = top_frame[7:0];
          end
          state_d = S_UPDATE;
        end
      end

      S_UPDATE: begin
        if (dec_pop_q) begin
          sp_d = sp_q - SPW'(1);
          if (sp_q == SPW'(1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            ex_req_d   = 1'b1;
            ex_frame_d = below_frame;
            state_d    = S_ISSUE;
          end
        end else if (dec_push_q) begin
          if (sp_q == SPW'(DEPTH)) begin
            // Overflow: stack untouched, search abandoned.
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_ERROR;
          end else begin
            wr_push    = 1'b1;
            wr_pos     = dec_upd_q;
            sp_d       = sp_q + SPW'(1);
            ex_req_d   = 1'b1;
            ex_frame_d = {NONE, dec_frame_q};
            state_d    = S_ISSUE;
          end
        end else begin
          wr_pos   = dec_upd_q;
          ex_req_d = 1'b1;
          if (dec_upd_q) begin
            ex_frame_d = {dec_pos_q, top_frame[31:0]};
          end else begin
            ex_frame_d = top_frame;
          end
          state_d = S_ISSUE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sp_q        <= '0;
      ex_frame_q  <= '0;
      ex_req_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      hit_valid_q <= 1'b0;
      hit_k_q     <= 8'd0;
      hit_l_q     <= 8'd0;
      dec_pop_q   <= 1'b0;
      dec_push_q  <= 1'b0;
      dec_upd_q   <= 1'b0;
      dec_pos_q   <= 5'd0;
      dec_frame_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      ex_frame_q  <= ex_frame_d;
      ex_req_q    <= ex_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      hit_valid_q <= hit_valid_d;
      hit_k_q     <= hit_k_d;
      hit_l_q     <= hit_l_d;
      dec_pop_q   <= dec_pop_d;
      dec_push_q  <= dec_push_d;
      dec_upd_q   <= dec_upd_d;
      dec_pos_q   <= dec_pos_d;
      dec_frame_q <= dec_frame_d;
    end
  end

  // Frame storage: root load on launch, push into entry sp, position rewrite of entry sp-1.
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (wr_root && (e == 0)) begin
        frames_q[e] <= {NONE, i0, z0, k0, l0};
      end else begin
        if (wr_push && (sp_q == SPW'(e))) begin
          frames_q[e] <= {NONE, dec_frame_q};
        end
        if (wr_pos && (sp_q == SPW'(e + 1))) begin
          frames_q[e][36:32] <= dec_pos_q;
        end
      end
    end
  end

`ifdef BT_HIT_CNT_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;

  // Saturating hit counter, cleared on every launch.
  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (launch) begin
      hit_cnt_d = 16'd0;
    end else if (hit_valid_d && (hit_cnt_q != 16'hFFFF)) begin
      hit_cnt_d = hit_cnt_q + 16'd1;
    end
  end

  // Hit counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q <= 16'd0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign hit_count = hit_cnt_q;
`else
  assign hit_count = 16'd0;
`endif

  assign ex_req      = ex_req_q;
  assign ex_position = ex_frame_q[36:32];
  assign ex_i        = ex_frame_q[31:24];
  assign ex_z        = ex_frame_q[23:16];
  assign ex_k        = ex_frame_q[15:8];
  assign ex_l        = ex_frame_q[7:0];
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign hit_valid   = hit_valid_q;
  assign hit_k       = hit_k_q;
  assign hit_l       = hit_l_q;
  assign depth       = sp_q;

endmodule

// File: tb/tb_bt_stack_ctrl.sv
// Testbench for bt_stack_ctrl: directed scenarios plus randomized searches,
// checked every cycle against a queue-based stack model.
`timescale 1ns/1ps
module tb_bt_stack_ctrl;

  localparam int DEPTH = 4;
  localparam int SPW   = $clog2(DEPTH + 1);
  localparam logic [4:0] P_NONE        = 5'd0;
  localparam logic [4:0] P_STOP_2      = 5'd2;
  localparam logic [4:0] P_A_INSERTION = 5'd4;
`ifdef BT_HIT_CNT_EN
  localparam logic [15:0] HC_ONE = 16'd1;
`else
  localparam logic [15:0] HC_ONE = 16'd0;
`endif

  typedef struct packed {
    logic [4:0] pos;
    logic [7:0] i, z, k, l;
  } frame_t;

  typedef struct packed {
    logic       o1, o2, fin, enp, nc;
    logic [4:0] np;
    logic [7:0] i, z, k, l;
  } dec_t;

  logic clk = 1'b0;
  logic rst_n, start, res_valid;
  logic [7:0] i0, z0, k0, l0;
  logic over_1, over_2, finish, en_new_position, new_call;
  logic [4:0] new_position;
  logic [7:0] i_new, z_new, k_new, l_new;
  logic ex_req, busy, done, err, hit_valid;
  logic [4:0] ex_position;
  logic [7:0] ex_i, ex_z, ex_k, ex_l, hit_k, hit_l;
  logic [15:0] hit_count;
  logic [SPW-1:0] depth;

  bt_stack_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .i0(i0), .z0(z0), .k0(k0), .l0(l0),
    .ex_req(ex_req), .ex_position(ex_position),
    .ex_i(ex_i), .ex_z(ex_z), .ex_k(ex_k), .ex_l(ex_l),
    .res_valid(res_valid), .over_1(over_1), .over_2(over_2), .finish(finish),
    .en_new_position(en_new_position), .new_call(new_call),
    .new_position(new_position),
    .i_new(i_new), .z_new(z_new), .k_new(k_new), .l_new(l_new),
    .busy(busy), .done(done), .err(err), .hit_valid(hit_valid),
    .hit_k(hit_k), .hit_l(hit_l), .hit_count(hit_count), .depth(depth)
  );

  always #5 clk = ~clk;

  // Reference model state
  frame_t stk[$];
  frame_t e_ex;
  logic   e_ex_req, e_done, e_busy, e_err, e_hit_valid;
  logic [7:0] e_hit_k, e_hit_l;
  int     e_hits;
  bit     chk_en = 1'b0;
  int     errors = 0;
  int     checks = 0;

  // DUT values captured in the UPDATE cycle for literal checks
  logic       upd_hv;
  logic [7:0] upd_hk, upd_hl;
  logic [15:0] upd_hc;

  function automatic logic [15:0] exp_hc();
`ifdef BT_HIT_CNT_EN
    return (e_hits > 65535) ? 16'hFFFF : 16'(e_hits);
`else
    return 16'd0;
`endif
  endfunction

  function automatic frame_t mkf(logic [4:0] p, logic [7:0] i, logic [7:0] z,
                                 logic [7:0] k, logic [7:0] l);
    frame_t f;
    f.pos = p; f.i = i; f.z = z; f.k = k; f.l = l;
    return f;
  endfunction

  function automatic dec_t mkd(logic o1, logic o2, logic fin, logic enp, logic nc,
                               logic [4:0] np, logic [7:0] i, logic [7:0] z,
                               logic [7:0] k, logic [7:0] l);
    dec_t d;
    d.o1 = o1; d.o2 = o2; d.fin = fin; d.enp = enp; d.nc = nc;
    d.np = np; d.i = i; d.z = z; d.k = k; d.l = l;
    return d;
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("ex_req", 64'(ex_req), 64'(e_ex_req));
      cmp("done", 64'(done), 64'(e_done));
      cmp("busy", 64'(busy), 64'(e_busy));
      cmp("err", 64'(err), 64'(e_err));
      cmp("hit_valid", 64'(hit_valid), 64'(e_hit_valid));
      cmp("hit_kl", 64'({hit_k, hit_l}), 64'({e_hit_k, e_hit_l}));
      cmp("hit_count", 64'(hit_count), 64'(exp_hc()));
      cmp("depth", 64'(depth), 64'(stk.size()));
      cmp("ex_frame", 64'({ex_position, ex_i, ex_z, ex_k, ex_l}), 64'(e_ex));
    end
  end

  task automatic reset_model();
    stk.delete();
    e_ex = '0; e_ex_req = 0; e_done = 0; e_busy = 0; e_err = 0;
    e_hit_valid = 0; e_hit_k = 0; e_hit_l = 0; e_hits = 0;
  endtask

  task automatic clear_dec();
    over_1 = 0; over_2 = 0; finish = 0; en_new_position = 0; new_call = 0;
    new_position = 0; i_new = 0; z_new = 0; k_new = 0; l_new = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e_ex_req = 0; e_done = 0; e_hit_valid = 0;
  endtask

  task automatic start_search(input logic [7:0] i, input logic [7:0] z,
                              input logic [7:0] k, input logic [7:0] l);
    i0 = i; z0 = z; k0 = k; l0 = l; start = 1;
    tick();
    start = 0;
    stk.delete();
    stk.push_back(mkf(P_NONE, i, z, k, l));
    e_err = 0; e_hits = 0; e_busy = 1; e_ex = stk[$]; e_ex_req = 1;
  endtask

  // Called in the ex_req cycle; returns in the cycle after UPDATE.
  task automatic decide(input dec_t d, input int lat, input bit spurious,
                        input bit busy_start, output bit ended);
    frame_t t;
    bit pop;
    ended = 0;
    if (spurious) begin
      res_valid = 1; over_1 = 1'($urandom); finish = 1'($urandom);
      new_call = 1'($urandom); en_new_position = 1'($urandom);
      new_position = 5'($urandom);
    end
    tick();
    res_valid = 0; clear_dec();
    for (int w = 1; w < lat; w++) begin
      if (busy_start) begin
        start = 1; i0 = 8'($urandom); z0 = 8'($urandom);
      end
      tick();
      start = 0;
    end
    res_valid = 1;
    over_1 = d.o1; over_2 = d.o2; finish = d.fin;
    en_new_position = d.enp; new_call = d.nc; new_position = d.np;
    i_new = d.i; z_new = d.z; k_new = d.k; l_new = d.l;
    tick();
    res_valid = 0; clear_dec();
    pop = d.o1 | d.o2 | d.fin;
    if (pop && d.o2) begin
      e_hit_valid = 1; e_hit_k = stk[$].k; e_hit_l = stk[$].l; e_hits++;
    end
    upd_hv = hit_valid; upd_hk = hit_k; upd_hl = hit_l; upd_hc = hit_count;
    tick();
    if (pop) begin
      void'(stk.pop_back());
      if (stk.size() == 0) begin
        e_done = 1; e_busy = 0; ended = 1;
      end else begin
        e_ex = stk[$]; e_ex_req = 1;
      end
    end else if (d.nc) begin
      if (stk.size() == DEPTH) begin
        e_err = 1; e_busy = 0; ended = 1;
      end else begin
        if (d.enp) begin
          t = stk[$]; t.pos = d.np; stk[stk.size() - 1] = t;
        end
        stk.push_back(mkf(P_NONE, d.i, d.z, d.k, d.l));
        e_ex = stk[$]; e_ex_req = 1;
      end
    end else begin
      if (d.enp) begin
        t = stk[$]; t.pos = d.np; stk[stk.size() - 1] = t;
      end
      e_ex = stk[$]; e_ex_req = 1;
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] expv);
    cmp(nm, 64'(act), 64'(expv));
  endtask

  initial begin
    bit   ended;
    dec_t d;
    int   nd, r;
    rst_n = 0; start = 0; res_valid = 0;
    i0 = 0; z0 = 0; k0 = 0; l0 = 0;
    clear_dec();
    reset_model();
    tick();
    chk_en = 1;
    tick();
    rst_n = 1;
    tick();
    lit("reset_ex_req", 32'(ex_req), 0);
    lit("reset_depth", 32'(depth), 0);
    lit("reset_busy", 32'(busy), 0);

    // Root prune
    start_search(8'd3, 8'd0, 8'h30, 8'h40);
    decide(mkd(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, ended);
    lit("prune_done", 32'(done), 1);
    lit("prune_depth", 32'(depth), 0);
    lit("prune_hits", 32'(hit_count), 0);
    $display("txn root-prune: done=%0d depth=%0d", done, depth);
    tick();

    // Push / pop / hit / position update
    start_search(8'd7, 8'd0, 8'h11, 8'h22);
    decide(mkd(0, 0, 0, 1, 1, P_STOP_2, 8'd2, 8'd1, 8'd5, 8'd9), 2, 0, 0, ended);
    lit("push_pos", 32'(ex_position), 32'(P_NONE));
    lit("push_i", 32'(ex_i), 2);
    lit("push_z", 32'(ex_z), 1);
    lit("push_k", 32'(ex_k), 5);
    lit("push_l", 32'(ex_l), 9);
    lit("push_depth", 32'(depth), 2);
    $display("txn push: depth=%0d", depth);
    decide(mkd(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, ended);
    lit("pop_pos", 32'(ex_position), 32'(P_STOP_2));
    lit("pop_depth", 32'(depth), 1);
    $display("txn pop: pos=%0d depth=%0d", ex_position, depth);
    decide(mkd(0, 0, 0, 1, 1, P_STOP_2, 8'd2, 8'd1, 8'd5, 8'd9), 1, 1, 0, ended);
    decide(mkd(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 3, 0, 1, ended);
    lit("hit_valid", 32'(upd_hv), 1);
    lit("hit_k", 32'(upd_hk), 5);
    lit("hit_l", 32'(upd_hl), 9);
    lit("hit_count", 32'(upd_hc), 32'(HC_ONE));
    $display("txn hit: k=%0d l=%0d count=%0d", upd_hk, upd_hl, upd_hc);
    decide(mkd(0, 0, 0, 1, 0, P_A_INSERTION, 0, 0, 0, 0), 1, 0, 0, ended);
    lit("upd_pos", 32'(ex_position), 32'(P_A_INSERTION));
    lit("upd_i", 32'(ex_i), 7);
    lit("upd_k", 32'(ex_k), 32'h11);
    $display("txn pos-update: pos=%0d", ex_position);
    decide(mkd(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, ended);
    tick();

    // Overflow
    start_search(8'd9, 8'd1, 8'h01, 8'h02);
    for (int n = 0; n < 4; n++)
      decide(mkd(0, 0, 0, 0, 1, 0, 8'(n), 8'd0, 8'(n + 1), 8'(n + 2)), 1, 0, 0, ended);
    lit("ovf_err", 32'(err), 1);
    lit("ovf_busy", 32'(busy), 0);
    lit("ovf_depth", 32'(depth), 4);
    lit("ovf_done", 32'(done), 0);
    $display("txn overflow: err=%0d depth=%0d", err, depth);
    tick(); tick();
    start_search(8'd1, 8'd0, 8'h03, 8'h04);
    lit("restart_err", 32'(err), 0);
    lit("restart_depth", 32'(depth), 1);

    // Reset mid-search at depth 3
    decide(mkd(0, 0, 0, 0, 1, 0, 8'd5, 8'd0, 8'd6, 8'd7), 1, 0, 0, ended);
    decide(mkd(0, 0, 0, 0, 1, 0, 8'd8, 8'd0, 8'd9, 8'd10), 1, 0, 0, ended);
    lit("pre_rst_depth", 32'(depth), 3);
    rst_n = 0;
    tick();
    reset_model();
    lit("rst_depth", 32'(depth), 0);
    lit("rst_ex_i", 32'(ex_i), 0);
    lit("rst_busy", 32'(busy), 0);
    tick();
    rst_n = 1;
    tick();
    start_search(8'd4, 8'd2, 8'h21, 8'h31);
    lit("post_rst_depth", 32'(depth), 1);
    $display("txn reset-mid-search: depth=%0d", depth);
    decide(mkd(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, ended);

    // Randomized searches
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 1) == 1) tick();
      start_search(8'($urandom), 8'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      ended = 0; nd = 0;
      while (!ended) begin
        r = $urandom_range(0, 99);
        d = mkd(0, 0, 0, 1'($urandom), 1'($urandom), 5'($urandom),
                8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        if (r < 32 || nd >= 30) begin
          d.o1 = 1'($urandom); d.o2 = 1'($urandom); d.fin = 1'($urandom);
          if (!(d.o1 | d.o2 | d.fin)) d.o2 = 1;
        end else if (r < 62) begin
          d.nc = 1;
        end else if (r < 80) begin
          d.nc = 0; d.enp = 1;
        end else begin
          d.nc = 0; d.enp = 0;
        end
        decide(d, $urandom_range(1, 4), 1'($urandom), 1'($urandom), ended);
        nd++;
      end
      $display("txn search %0d: %0d decisions, ended by %s, hits=%0d",
               s, nd, e_err ? "overflow" : "empty stack", e_hits);
    end
    tick(); tick();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
